// File: rtl/serial_frame_rx.sv
// serial_frame_rx
// Receives one frame on a single serial line that shares the system clock.
// Frame format: start bit (1), DATA_BITS data bits LSB first, stop bit (0).
// Each bit lasts BIT_CYCLES clocks. Every bit after the start bit is sampled
// H = (BIT_CYCLES-1)/2 cycles after the start edge, which places the sample
// near the middle of the bit. A good frame loads data_out and pulses
// data_valid for one cycle. A bad stop bit pulses frame_err for one cycle.
// After a bad stop bit the receiver waits for the line to return to idle
// before it accepts a new start bit.

module serial_frame_rx #(
   parameter int DATA_BITS  = 8,
   parameter int BIT_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 a_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   output logic                 frame_err,
   output logic                 busy
);

   localparam int H  = (BIT_CYCLES - 1) / 2;
   localparam int CW = $clog2(BIT_CYCLES) + 1;
   localparam int BW = $clog2(DATA_BITS + 1);

   // Terminal counts for the start re-sample, bit period and last data bit.
   localparam logic [CW-1:0] H_LAST    = (H > 0) ? CW'(H - 1) : '0;
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_IDLE = 3'd4
   } state_e;

   state_e               state_q;
   logic [CW-1:0]        cyc_q;
   logic [BW-1:0]        bit_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [DATA_BITS-1:0] data_q;
   logic                 valid_q;
   logic                 err_q;
   logic                 busy_q;

   // Frame FSM. All outputs are registered here.
   // NOTE: clocked state uses non-blocking (<=) assignments only. This makes
   // every branch read the values from before the edge, whatever order the
   // statements are written in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         // NOTE: the strobes default low at every edge. An output is therefore
         // high for exactly one cycle, and no branch needs its own clear.
         valid_q <= 1'b0;
         err_q   <= 1'b0;

         case (state_q)
            IDLE: begin
               cyc_q <= '0;
               bit_q <= '0;
               if (a_in) begin
                  busy_q <= 1'b1;
                  // With a zero mid-bit offset, this edge is already the
                  // start sample.
                  if (H > 0) state_q <= START;
                  else       state_q <= DATA;
               end
            end

            START: begin
               if (cyc_q == H_LAST) begin
                  cyc_q <= '0;
                  if (a_in) begin
                     state_q <= DATA;
                  end else begin
                     // Short glitch on the line: drop it without a pulse.
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end
               end else begin
                  cyc_q <= cyc_q + CW'(1);
               end
            end

            DATA: begin
               if (cyc_q == BIT_LAST) begin
                  cyc_q <= '0;
                  for (int i = 0; i < DATA_BITS; i++) begin
                     if (bit_q == BW'(i)) shift_q[i] <= a_in;
                  end
                  if (bit_q == DATA_LAST) begin
                     bit_q   <= '0;
                     state_q <= STOP;
                  end else begin
                     bit_q <= bit_q + BW'(1);
                  end
               end else begin
                  cyc_q <= cyc_q + CW'(1);
               end
            end

            STOP: begin
               if (cyc_q == BIT_LAST) begin
                  cyc_q <= '0;
                  if (!a_in) begin
                     data_q  <= shift_q;
                     valid_q <= 1'b1;
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     // data_out keeps the last good word.
                     err_q   <= 1'b1;
                     state_q <= WAIT_IDLE;
                  end
               end else begin
                  cyc_q <= cyc_q + CW'(1);
               end
            end

            WAIT_IDLE: begin
               // A line stuck high must not be read as a new start bit.
               if (!a_in) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end

            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               cyc_q   <= '0;
               bit_q   <= '0;
            end
         endcase
      end
   end

   assign data_out   = data_q;
   assign data_valid = valid_q;
   assign frame_err  = err_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_serial_frame_rx.sv
// tb_serial_frame_rx
// Directed checks of serial_frame_rx using two instances:
//   u_rx1 : BIT_CYCLES = 1 (H = 0)
//   u_rx4 : BIT_CYCLES = 4 (H = 1)
// Both instances share clk and rst_n. Inputs change 1 time unit after a rising
// edge, and outputs are sampled at that same point.

module tb_serial_frame_rx;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b0;
   logic       a1    = 1'b0;
   logic       a4    = 1'b0;
   logic [7:0] d1, d4;
   logic       v1, e1, b1, v4, e4, b4;

   int total = 0;
   int bad   = 0;

   // Clock: 10-unit period.
   always #5 clk = ~clk;

   serial_frame_rx #(.DATA_BITS(8), .BIT_CYCLES(1)) u_rx1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .a_in       (a1),
      .data_out   (d1),
      .data_valid (v1),
      .frame_err  (e1),
      .busy       (b1)
   );

   serial_frame_rx #(.DATA_BITS(8), .BIT_CYCLES(4)) u_rx4 (
      .clk        (clk),
      .rst_n      (rst_n),
      .a_in       (a4),
      .data_out   (d4),
      .data_valid (v4),
      .frame_err  (e4),
      .busy       (b4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Step to the next rising edge and settle 1 unit after it.
   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Send one good 1-cycle-per-bit frame on a1. Edges E0..E9 sample the bits.
   task automatic send1(input logic [7:0] d);
      logic [9:0] f;
      f = {1'b0, d, 1'b1};
      for (int i = 0; i < 10; i++) begin
         a1 = f[i];
         tick();
      end
   endtask

   initial begin
      logic [19:0] bb;
      logic [9:0]  f;
      int          nv, ne, vpos;
      int          pos[2];
      logic [7:0]  got[2];

      // ---- Reset held while the line toggles ----
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         a1 = ~a1;
         a4 = ~a4;
         tick();
         check("rst_out1", 32'({d1, v1, e1, b1}), 32'd0);
         check("rst_out4", 32'({d4, v4, e4, b4}), 32'd0);
      end
      a1 = 1'b0;
      a4 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         tick();
         check("idle_quiet", 32'({v1, e1, b1, v4, e4, b4}), 32'd0);
      end

      // ---- Back-to-back frames 0x3C then 0xFF (BIT_CYCLES=1) ----
      bb = {1'b0, 8'hFF, 1'b1, 1'b0, 8'h3C, 1'b1};
      nv = 0;
      ne = 0;
      pos[0] = -1; pos[1] = -1;
      got[0] = '0; got[1] = '0;
      for (int i = 0; i < 20; i++) begin
         a1 = bb[i];
         tick();
         if (e1) ne++;
         if (v1) begin
            if (nv < 2) begin
               pos[nv] = i;
               got[nv] = d1;
            end
            nv++;
         end
      end
      check("b2b_count", 32'(nv), 32'd2);
      check("b2b_pos0", 32'(pos[0]), 32'd9);
      check("b2b_pos1", 32'(pos[1]), 32'd19);
      check("b2b_data0", 32'(got[0]), 32'h3C);
      check("b2b_data1", 32'(got[1]), 32'hFF);
      check("b2b_noerr", 32'(ne), 32'd0);
      a1 = 1'b0;
      tick();
      check("b2b_end", 32'({v1, e1, b1}), 32'd0);

      // ---- Single frame 0xA5: busy after E0..E8, valid after E9 ----
      f = {1'b0, 8'hA5, 1'b1};
      for (int i = 0; i < 10; i++) begin
         a1 = f[i];
         tick();
         if (i < 9) check("a5_busy", 32'({b1, v1, e1}), 32'b100);
      end
      check("a5_valid", 32'({b1, v1, e1}), 32'b010);
      check("a5_data", 32'(d1), 32'hA5);
      a1 = 1'b0;
      tick();
      check("a5_pulse_end", 32'({b1, v1, e1}), 32'd0);
      check("a5_hold", 32'(d1), 32'hA5);

      // ---- Bad stop bit on a frame carrying 0x12 ----
      f = {1'b1, 8'h12, 1'b1};
      for (int i = 0; i < 10; i++) begin
         a1 = f[i];
         tick();
      end
      check("ferr_pulse", 32'({b1, v1, e1}), 32'b101);
      check("ferr_data", 32'(d1), 32'hA5);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("ferr_wait", 32'({b1, v1, e1}), 32'b100);
      end
      a1 = 1'b0;
      tick();
      check("ferr_release", 32'({b1, v1, e1}), 32'd0);
      send1(8'h66);
      check("ferr_next_valid", 32'({b1, v1, e1}), 32'b010);
      check("ferr_next_data", 32'(d1), 32'h66);
      a1 = 1'b0;
      tick();

      // ---- BIT_CYCLES=4: one-cycle glitch is rejected at E1 ----
      a4 = 1'b1;
      tick();
      check("glitch_busy", 32'(b4), 32'd1);
      a4 = 1'b0;
      tick();
      check("glitch_idle", 32'({b4, v4, e4}), 32'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         check("glitch_quiet", 32'({b4, v4, e4}), 32'd0);
      end

      // ---- BIT_CYCLES=4: 40-cycle frame 0x5A, valid after E37 ----
      f = {1'b0, 8'h5A, 1'b1};
      nv = 0;
      ne = 0;
      vpos = -1;
      for (int e = 0; e < 40; e++) begin
         a4 = f[e / 4];
         tick();
         if (v4) begin
            nv++;
            vpos = e;
         end
         if (e4) ne++;
         if (e == 0)  check("bc4_busy_e0", 32'(b4), 32'd1);
         if (e == 36) check("bc4_busy_e36", 32'(b4), 32'd1);
      end
      check("bc4_count", 32'(nv), 32'd1);
      check("bc4_pos", 32'(vpos), 32'd37);
      check("bc4_data", 32'(d4), 32'h5A);
      check("bc4_noerr", 32'(ne), 32'd0);
      check("bc4_idle", 32'(b4), 32'd0);
      a4 = 1'b0;

      // ---- Reset during data bit 4 of a 0x81 frame ----
      f = {1'b0, 8'h81, 1'b1};
      for (int i = 0; i < 6; i++) begin
         a1 = f[i];
         tick();
      end
      check("mid_busy", 32'(b1), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst1", 32'({d1, v1, e1, b1}), 32'd0);
      check("mid_rst4", 32'(d4), 32'd0);
      a1 = 1'b1;
      tick();
      tick();
      check("mid_rst_hold", 32'({d1, v1, e1, b1}), 32'd0);
      rst_n = 1'b1;
      a1 = 1'b0;
      tick();
      check("post_rst_idle", 32'({v1, e1, b1}), 32'd0);
      send1(8'h81);
      check("post_rst_valid", 32'({b1, v1, e1}), 32'b010);
      check("post_rst_data", 32'(d1), 32'h81);
      a1 = 1'b0;
      tick();
      check("post_rst_end", 32'({v1, e1, b1}), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
